// File: rtl/gsim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gsim_sequencer
//  Description : Control sequencer for a Gauss-Seidel solver. Loads one
//                b vector, runs RUN in-place sweeps over N rows with a
//                two-cycle compute slot per row and a +/-3 neighbour window,
//                then streams the N solution words out.
//  Revision    : 1.0 - initial release
// ============================================================================
module gsim_sequencer #(
    parameter int N   = 16,
    parameter int RUN = 50,
    parameter int AW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_en,
    output logic            b_wr_en,
    output logic [AW-1:0]   b_wr_addr,
    output logic            x_clr,
    output logic [AW-1:0]   row_idx,
    output logic [6*AW-1:0] nbr_addr,
    output logic [5:0]      nbr_zero,
    output logic            issue,
    output logic            x_wr_en,
    output logic [AW-1:0]   x_wr_addr,
    output logic            out_valid,
    output logic [AW-1:0]   out_idx,
    output logic            busy
);

    // Sweep counter only has to reach RUN-1; the wrap at that value ends ITER.
    localparam int SW = (RUN > 1) ? $clog2(RUN) : 1;

    localparam logic [AW-1:0]        c_last_row   = AW'(N - 1);
    localparam logic [AW-1:0]        c_one        = AW'(1);
    localparam logic [SW-1:0]        c_last_sweep = SW'(RUN - 1);
    localparam logic [SW-1:0]        c_sweep_one  = SW'(1);
    localparam logic signed [AW:0]   c_max_idx    = (AW + 1)'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] load_q,  load_d;
    logic [AW-1:0] row_q,   row_d;
    logic [AW-1:0] out_q,   out_d;
    logic          slot_q,  slot_d;     // 0 = slot A (issue), 1 = slot B (write-back)
    logic [SW-1:0] sweep_q, sweep_d;

    logic               w_iter;
    logic signed [AW:0] w_row_s;

    // State and counter registers; reset returns every counter to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            load_q  <= '0;
            row_q   <= '0;
            out_q   <= '0;
            slot_q  <= 1'b0;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            row_q   <= row_d;
            out_q   <= out_d;
            slot_q  <= slot_d;
            sweep_q <= sweep_d;
        end
    end

    // Next-state logic and strobe decode for load, iterate and output phases.
    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        row_d     = row_q;
        out_d     = out_q;
        slot_d    = slot_q;
        sweep_d   = sweep_q;
        b_wr_en   = 1'b0;
        x_clr     = 1'b0;
        issue     = 1'b0;
        x_wr_en   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The first b word is written in the same cycle the strobe
                // arrives, so write enable and x clear follow in_en directly.
                // Reset must still suppress the write.
                if (in_en && !reset) begin
                    b_wr_en = 1'b1;
                    x_clr   = 1'b1;
                    if (N == 1) begin
                        state_d = ST_ITER;
                        load_d  = '0;
                        row_d   = '0;
                        slot_d  = 1'b0;
                        sweep_d = '0;
                    end else begin
                        state_d = ST_LOAD;
                        load_d  = c_one;
                    end
                end
            end

            ST_LOAD: begin
                if (in_en && !reset) begin
                    b_wr_en = 1'b1;
                    if (load_q == c_last_row) begin
                        state_d = ST_ITER;
                        load_d  = '0;
                        row_d   = '0;
                        slot_d  = 1'b0;
                        sweep_d = '0;
                    end else begin
                        load_d = load_q + c_one;
                    end
                end
            end

            ST_ITER: begin
                if (!slot_q) begin
                    issue  = 1'b1;
                    slot_d = 1'b1;
                end else begin
                    // Write-back lands before the next row is issued, so
                    // row i+1 already sees the fresh x[i].
                    x_wr_en = 1'b1;
                    slot_d  = 1'b0;
                    if (row_q == c_last_row) begin
                        row_d = '0;
                        if (sweep_q == c_last_sweep) begin
                            sweep_d = '0;
                            out_d   = '0;
                            state_d = ST_OUT;
                        end else begin
                            sweep_d = sweep_q + c_sweep_one;
                        end
                    end else begin
                        row_d = row_q + c_one;
                    end
                end
            end

            ST_OUT: begin
                out_valid = 1'b1;
                if (out_q == c_last_row) begin
                    out_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    out_d = out_q + c_one;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_iter    = (state_q == ST_ITER);
    assign busy      = (state_q != ST_IDLE);
    assign b_wr_addr = load_q;
    assign row_idx   = row_q;
    assign x_wr_addr = row_q;
    assign out_idx   = out_q;
    assign w_row_s   = $signed({1'b0, row_q});

    // Neighbour window. Address slice k (LSB first) carries i-1, i+1, i-2,
    // i+2, i-3, i+3. The zero flags are packed in the opposite order:
    // nbr_zero[5] flags i-1 and nbr_zero[0] flags i+3, so row 0 reads
    // 6'b101010. Outside ITER every operand is forced to zero.
    for (genvar k = 0; k < 6; k++) begin : g_nbr
        localparam logic signed [AW:0] c_dist = (AW + 1)'(k / 2 + 1);
        logic signed [AW:0] w_idx;
        logic               w_oob;

        if (k % 2 == 0) begin : g_minus
            assign w_idx = w_row_s - c_dist;
        end else begin : g_plus
            assign w_idx = w_row_s + c_dist;
        end

        // A sum past the signed range wraps negative, which is also out of range.
        assign w_oob                = w_idx[AW] || (w_idx > c_max_idx);
        assign nbr_addr[k*AW +: AW] = (w_iter && !w_oob) ? w_idx[AW-1:0] : '0;
        assign nbr_zero[5-k]        = !w_iter || w_oob;
    end

endmodule
`default_nettype wire

// File: tb/tb_gsim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gsim_sequencer
//  Description : Directed self-checking bench for gsim_sequencer
//                (N=16, RUN=50, AW=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gsim_sequencer;

    localparam int N   = 16;
    localparam int RUN = 50;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_en;
    logic          b_wr_en;
    logic [AW-1:0] b_wr_addr;
    logic          x_clr;
    logic [AW-1:0] row_idx;
    logic [23:0]   nbr_addr;
    logic [5:0]    nbr_zero;
    logic          issue;
    logic          x_wr_en;
    logic [AW-1:0] x_wr_addr;
    logic          out_valid;
    logic [AW-1:0] out_idx;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gsim_sequencer #(.N(N), .RUN(RUN), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .b_wr_en   (b_wr_en),
        .b_wr_addr (b_wr_addr),
        .x_clr     (x_clr),
        .row_idx   (row_idx),
        .nbr_addr  (nbr_addr),
        .nbr_zero  (nbr_zero),
        .issue     (issue),
        .x_wr_en   (x_wr_en),
        .x_wr_addr (x_wr_addr),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe vector order: {busy, issue, x_wr_en, b_wr_en, x_clr, out_valid}
    task automatic test_reset();
        reset = 1'b1;
        in_en = 1'b1;
        #1;
        n_cmp++;
        if (b_wr_en !== 1'b0) begin
            n_err++; $display("FAIL rst_override_bwr: got %b want 0", b_wr_en);
        end
        tick();
        tick();
        n_cmp++;
        if ({busy, issue, x_wr_en, b_wr_en, x_clr, out_valid} !== 6'b000000) begin
            n_err++; $display("FAIL rst_strobes: got %b want 000000",
                              {busy, issue, x_wr_en, b_wr_en, x_clr, out_valid});
        end
        n_cmp++;
        if (nbr_zero !== 6'b111111) begin
            n_err++; $display("FAIL rst_nbr_zero: got %b want 111111", nbr_zero);
        end
        n_cmp++;
        if ({nbr_addr, row_idx, b_wr_addr, out_idx} !== 36'd0) begin
            n_err++; $display("FAIL rst_addrs: nbr_addr %h row %0d b_addr %0d out %0d want all 0",
                              nbr_addr, row_idx, b_wr_addr, out_idx);
        end
        reset = 1'b0;
        in_en = 1'b0;
        tick();
        n_cmp++;
        if ({busy, b_wr_en, x_clr} !== 3'b000) begin
            n_err++; $display("FAIL rst_idle: got %b want 000", {busy, b_wr_en, x_clr});
        end
    endtask

    // 16 consecutive b words; ends in the first ITER cycle.
    task automatic test_load();
        int clr_cnt = 0;
        for (int c = 0; c < N; c++) begin
            in_en = 1'b1;
            #1;
            n_cmp++;
            if ({b_wr_en, b_wr_addr} !== {1'b1, 4'(c)}) begin
                n_err++; $display("FAIL load_write c=%0d: got en=%b addr=%0d want en=1 addr=%0d",
                                  c, b_wr_en, b_wr_addr, c);
            end
            n_cmp++;
            if (busy !== (c != 0)) begin
                n_err++; $display("FAIL load_busy c=%0d: got %b want %b", c, busy, (c != 0));
            end
            if (x_clr === 1'b1) clr_cnt++;
            tick();
        end
        in_en = 1'b0;
        #1;
        n_cmp++;
        if (clr_cnt != 1) begin
            n_err++; $display("FAIL load_xclr_count: got %0d want 1", clr_cnt);
        end
        n_cmp++;
        if ({busy, issue, x_wr_en, b_wr_en, row_idx} !== {4'b1100, 4'd0}) begin
            n_err++; $display("FAIL load_iter_entry: got busy/issue/xwr/bwr=%b row=%0d want 1100 row=0",
                              {busy, issue, x_wr_en, b_wr_en}, row_idx);
        end
    endtask

    // in_en pattern 1,0,1 then steady; the hold cycle writes nothing.
    task automatic test_load_hold();
        in_en = 1'b1;
        #1;
        n_cmp++;
        if ({b_wr_en, x_clr, b_wr_addr} !== {2'b11, 4'd0}) begin
            n_err++; $display("FAIL hold_first: got en/clr=%b addr=%0d want 11 addr=0",
                              {b_wr_en, x_clr}, b_wr_addr);
        end
        tick();
        in_en = 1'b0;
        #1;
        n_cmp++;
        if ({busy, b_wr_en, x_clr, b_wr_addr} !== {3'b100, 4'd1}) begin
            n_err++; $display("FAIL hold_gap: got busy/en/clr=%b addr=%0d want 100 addr=1",
                              {busy, b_wr_en, x_clr}, b_wr_addr);
        end
        tick();
        for (int c = 1; c < N; c++) begin
            in_en = 1'b1;
            #1;
            n_cmp++;
            if ({b_wr_en, x_clr, b_wr_addr} !== {2'b10, 4'(c)}) begin
                n_err++; $display("FAIL hold_write c=%0d: got en/clr=%b addr=%0d want 10 addr=%0d",
                                  c, {b_wr_en, x_clr}, b_wr_addr, c);
            end
            tick();
        end
        n_cmp++;
        if ({busy, issue, row_idx} !== {2'b11, 4'd0}) begin
            n_err++; $display("FAIL hold_iter_entry: got busy/issue=%b row=%0d want 11 row=0",
                              {busy, issue}, row_idx);
        end
    endtask

    // Full ITER phase from its first cycle; exactly 2*N*RUN cycles.
    task automatic test_iter(input bit hold);
        in_en = hold;
        #1;
        for (int t = 0; t < 2 * N * RUN; t++) begin
            int         row;
            bit         slotb;
            logic [5:0] ez;
            logic [23:0] ea;
            row   = (t / 2) % N;
            slotb = (t % 2) == 1;
            n_cmp++;
            if ({busy, issue, x_wr_en, b_wr_en, x_clr, out_valid} !== {1'b1, !slotb, slotb, 3'b000}) begin
                n_err++; $display("FAIL iter_strobes t=%0d: got %b want %b", t,
                                  {busy, issue, x_wr_en, b_wr_en, x_clr, out_valid},
                                  {1'b1, !slotb, slotb, 3'b000});
            end
            n_cmp++;
            if (row_idx !== 4'(row)) begin
                n_err++; $display("FAIL iter_row t=%0d: got %0d want %0d", t, row_idx, row);
            end
            if (slotb) begin
                n_cmp++;
                if (x_wr_addr !== 4'(row)) begin
                    n_err++; $display("FAIL iter_xaddr t=%0d: got %0d want %0d", t, x_wr_addr, row);
                end
            end
            if (t == 0) begin
                n_cmp++;
                if (nbr_zero !== 6'b101010) begin
                    n_err++; $display("FAIL nbr_row0: got %b want 101010", nbr_zero);
                end
            end
            if (t == 14) begin
                n_cmp++;
                if ({nbr_zero, nbr_addr} !== {6'd0, 4'd10, 4'd4, 4'd9, 4'd5, 4'd8, 4'd6}) begin
                    n_err++; $display("FAIL nbr_row7: got zero=%b addr=%h want zero=000000 addr=a49586",
                                      nbr_zero, nbr_addr);
                end
            end
            if (t == 31) begin
                n_cmp++;
                if (nbr_zero !== 6'b010101) begin
                    n_err++; $display("FAIL nbr_row15: got %b want 010101", nbr_zero);
                end
            end
            if (t < 2 * N) begin
                for (int k = 0; k < 6; k++) begin
                    int v;
                    v = (k % 2 == 0) ? row - (k / 2 + 1) : row + (k / 2 + 1);
                    ez[5-k] = (v < 0) || (v > N - 1);
                    ea[k*4 +: 4] = ez[5-k] ? 4'd0 : 4'(v);
                end
                n_cmp++;
                if ({nbr_zero, nbr_addr} !== {ez, ea}) begin
                    n_err++; $display("FAIL nbr_model row=%0d: got zero=%b addr=%h want zero=%b addr=%h",
                                      row, nbr_zero, nbr_addr, ez, ea);
                end
            end
            tick();
        end
    endtask

    // Output stream of N words, then back to IDLE.
    task automatic test_out();
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if ({busy, issue, x_wr_en, b_wr_en, x_clr, out_valid} !== 6'b100001) begin
                n_err++; $display("FAIL out_strobes j=%0d: got %b want 100001", j,
                                  {busy, issue, x_wr_en, b_wr_en, x_clr, out_valid});
            end
            n_cmp++;
            if (out_idx !== 4'(j)) begin
                n_err++; $display("FAIL out_idx j=%0d: got %0d want %0d", j, out_idx, j);
            end
            tick();
        end
        n_cmp++;
        if ({busy, out_valid} !== 2'b00) begin
            n_err++; $display("FAIL out_done: got busy/valid=%b want 00", {busy, out_valid});
        end
    endtask

    // in_en still high in the IDLE cycle right after OUT starts a new load.
    task automatic test_back_to_back();
        n_cmp++;
        if ({busy, b_wr_en, x_clr, b_wr_addr} !== {3'b011, 4'd0}) begin
            n_err++; $display("FAIL b2b_start: got busy/en/clr=%b addr=%0d want 011 addr=0",
                              {busy, b_wr_en, x_clr}, b_wr_addr);
        end
        test_load();
    endtask

    // Reset at sweep 10, row 5 (330 cycles into ITER).
    task automatic test_reset_mid_iter();
        in_en = 1'b0;
        for (int t = 0; t < 10 * 2 * N + 5 * 2; t++) tick();
        n_cmp++;
        if ({issue, row_idx} !== {1'b1, 4'd5}) begin
            n_err++; $display("FAIL mid_pos: got issue=%b row=%0d want issue=1 row=5", issue, row_idx);
        end
        reset = 1'b1;
        in_en = 1'b1;
        tick();
        n_cmp++;
        if ({busy, issue, x_wr_en, b_wr_en, x_clr, out_valid} !== 6'b000000) begin
            n_err++; $display("FAIL mid_rst_strobes: got %b want 000000",
                              {busy, issue, x_wr_en, b_wr_en, x_clr, out_valid});
        end
        n_cmp++;
        if ({nbr_zero, nbr_addr, row_idx, b_wr_addr} !== {6'b111111, 32'd0}) begin
            n_err++; $display("FAIL mid_rst_state: got zero=%b addr=%h row=%0d baddr=%0d want 111111/0/0/0",
                              nbr_zero, nbr_addr, row_idx, b_wr_addr);
        end
        reset = 1'b0;
        in_en = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL mid_idle: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_en = 1'b0;
        test_reset();
        test_load();
        test_iter(1'b0);
        test_out();
        test_load_hold();
        test_iter(1'b1);
        test_out();
        test_back_to_back();
        test_reset_mid_iter();
        test_load();
        test_iter(1'b0);
        test_out();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
